// File: rtl/enc_engine_scheduler_pkg.sv
// Shared state encoding, default sizes and helpers for the encoder engine scheduler.
package enc_sched_pkg;

  localparam int BITSIZE  = 16;
  localparam int IN_SIZE  = 92;
  localparam int OUT_SIZE = 2;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } schedState_e;

  // Increment with wrap-around; n is the number of legal values (0..n-1).
  function automatic int unsigned wrapInc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/enc_engine_scheduler_if.sv
// Requester, engine and response bundle of the encoder engine scheduler.
// master is the surrounding system (requesters, engine, consumer); slave is the scheduler.
interface enc_engine_scheduler_if #(
  parameter int BITSIZE  = enc_sched_pkg::BITSIZE,
  parameter int IN_SIZE  = enc_sched_pkg::IN_SIZE,
  parameter int OUT_SIZE = enc_sched_pkg::OUT_SIZE,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*IN_SIZE*BITSIZE-1:0] req_x;
  logic [NUM_REQ-1:0]                 req_ready;

  logic                               eng_clear;
  logic [IN_SIZE*BITSIZE-1:0]         eng_x;
  logic [OUT_SIZE*BITSIZE-1:0]        eng_y;
  logic                               eng_done;

  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [ID_W-1:0]                    rsp_id;
  logic [OUT_SIZE*BITSIZE-1:0]        rsp_y;
  logic                               rsp_err;

  logic                               busy;

  modport master (
    output req_valid, req_x, eng_y, eng_done, rsp_ready,
    input  req_ready, eng_clear, eng_x, rsp_valid, rsp_id, rsp_y, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_x, eng_y, eng_done, rsp_ready,
    output req_ready, eng_clear, eng_x, rsp_valid, rsp_id, rsp_y, rsp_err, busy
  );

endinterface

// File: rtl/enc_engine_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr_i.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_o
);

  localparam logic [ID_W:0] NumReqW = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] cand;

  // ptr_i is always below NUM_REQ, so a single subtraction is enough to wrap.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_i} + (ID_W+1)'(i);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!any_o && req_i[cand[ID_W-1:0]]) begin
        any_o                    = 1'b1;
        gnt_o[cand[ID_W-1:0]]    = 1'b1;
        gnt_idx_o                = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/enc_engine_scheduler.sv
// Round-robin job scheduler sharing one encoder dot-product engine among NUM_REQ requesters.
// Optional engine watchdog enabled by defining ENC_SCHED_WATCHDOG_EN.
module enc_engine_scheduler #(
  parameter int BITSIZE  = enc_sched_pkg::BITSIZE,
  parameter int IN_SIZE  = enc_sched_pkg::IN_SIZE,
  parameter int OUT_SIZE = enc_sched_pkg::OUT_SIZE,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int MAX_WAIT = 64
) (
  input logic                    clk,
  input logic                    reset,
  enc_engine_scheduler_if.slave  bus
);

  import enc_sched_pkg::*;

  localparam int VecW = IN_SIZE * BITSIZE;
  localparam int ResW = OUT_SIZE * BITSIZE;

  schedState_e                     state_q;
  logic [ID_W-1:0]                 ptr_q;
  logic [ID_W-1:0]                 id_q;
  logic [VecW-1:0]                 engX_q;
  logic [ResW-1:0]                 rspY_q;
  logic                            engClear_q;
  logic                            rspValid_q;
  logic                            firstWait_q;
  logic                            rspErr;
  logic                            waitExpired;

  logic [NUM_REQ-1:0]              gnt;
  logic [ID_W-1:0]                 gntIdx;
  logic                            gntAny;
  logic                            grantNow;
  logic                            doneSeen;
  logic [NUM_REQ-1:0][VecW-1:0]    reqVec;

  assign reqVec   = bus.req_x;
  assign grantNow = (state_q == IDLE) && gntAny && !reset;
  // The engine's done is registered, so the first WAIT cycle still shows the previous job's level.
  assign doneSeen = bus.eng_done && !firstWait_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gntIdx),
    .any_o     (gntAny)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      engX_q      <= '0;
      rspY_q      <= '0;
      engClear_q  <= 1'b0;
      rspValid_q  <= 1'b0;
      firstWait_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grantNow) begin
            engX_q     <= reqVec[gntIdx];
            id_q       <= gntIdx;
            ptr_q      <= ID_W'(wrapInc(32'(gntIdx), NUM_REQ));
            engClear_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          engClear_q  <= 1'b0;
          firstWait_q <= 1'b1;
          state_q     <= WAIT;
        end
        WAIT: begin
          firstWait_q <= 1'b0;
          if (doneSeen) begin
            rspY_q     <= bus.eng_y;
            rspValid_q <= 1'b1;
            state_q    <= RESP;
          end else if (waitExpired) begin
            rspY_q     <= '0;
            rspValid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ENC_SCHED_WATCHDOG_EN
  localparam int CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] waitCnt_q;
  logic            rspErr_q;

  assign waitExpired = (waitCnt_q == CntW'(MAX_WAIT - 1));
  assign rspErr      = rspErr_q;

  // Counts elapsed WAIT cycles; the error flag lives exactly as long as the timed-out response.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      if (state_q == WAIT) begin
        waitCnt_q <= waitCnt_q + 1'b1;
        if (!doneSeen && waitExpired) begin
          rspErr_q <= 1'b1;
        end
      end else begin
        waitCnt_q <= '0;
      end
      if (state_q == RESP && bus.rsp_ready) begin
        rspErr_q <= 1'b0;
      end
    end
  end
`else
  logic unusedMaxWait;

  assign waitExpired   = 1'b0;
  assign rspErr        = 1'b0;
  assign unusedMaxWait = ^MAX_WAIT;
`endif

  assign bus.req_ready = grantNow ? gnt : '0;
  assign bus.eng_clear = engClear_q;
  assign bus.eng_x     = engX_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = rspY_q;
  assign bus.rsp_err   = rspErr;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_enc_engine_scheduler.sv
// Scoreboard bench for enc_engine_scheduler with a stub engine; covers ENC_SCHED_WATCHDOG_EN on or off.
module tb_enc_engine_scheduler;

  import enc_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int MAXW  = 8;
  localparam int VEC_W = IN_SIZE * BITSIZE;
  localparam int RES_W = OUT_SIZE * BITSIZE;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [RES_W-1:0] y;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  enc_engine_scheduler_if #(
    .BITSIZE(BITSIZE), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .NUM_REQ(NREQ), .ID_W(IDW)
  ) bus ();

  enc_engine_scheduler #(
    .BITSIZE(BITSIZE), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE),
    .NUM_REQ(NREQ), .ID_W(IDW), .MAX_WAIT(MAXW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   expGnt[$];
  rsp_t expRsp[$];

  // Stub engine: done rises stubLat cycles after the clear pulse and stays high until the next clear.
  int                 stubLat    = 5;
  bit                 stubNever  = 1'b0;
  bit                 manualMode = 1'b0;
  logic               manualDone = 1'b0;
  logic [RES_W-1:0]   stubY      = '0;
  int                 stubCnt    = 0;
  bit                 stubRun    = 1'b0;
  logic               stubDone   = 1'b0;

  logic [NREQ-1:0][VEC_W-1:0] reqVecs;

  assign bus.req_x    = reqVecs;
  assign bus.eng_y    = stubY;
  assign bus.eng_done = manualMode ? manualDone : stubDone;

  always @(posedge clk) begin
    if (reset) begin
      stubRun  <= 1'b0;
      stubDone <= 1'b0;
      stubCnt  <= 0;
    end else if (bus.eng_clear) begin
      stubRun  <= 1'b1;
      stubDone <= 1'b0;
      stubCnt  <= 1;
    end else if (stubRun && !stubNever) begin
      if (stubCnt == stubLat - 1) begin
        stubDone <= 1'b1;
        stubRun  <= 1'b0;
      end else begin
        stubCnt <= stubCnt + 1;
      end
    end
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] fillVec(input logic [BITSIZE-1:0] w);
    logic [IN_SIZE-1:0][BITSIZE-1:0] v;
    for (int i = 0; i < IN_SIZE; i++) v[i] = w;
    return v;
  endfunction

  function automatic logic [31:0] vecSig(input logic [VEC_W-1:0] vin);
    logic [IN_SIZE-1:0][BITSIZE-1:0] v;
    logic [31:0] s;
    v = vin;
    s = '0;
    for (int i = 0; i < IN_SIZE; i++) s = s + 32'(v[i]) * 32'(i + 1);
    return s;
  endfunction

  function automatic rsp_t mkRsp(input int id, input logic [RES_W-1:0] y, input logic err);
    rsp_t r;
    r.id  = IDW'(id);
    r.y   = y;
    r.err = err;
    return r;
  endfunction

  // Monitor: every accepted grant and every completed response is matched against the queues.
  always @(negedge clk) begin
    int   g;
    rsp_t e;
    if (!reset && bus.req_ready != '0) begin
      checkVal("grant_pending", 64'(expGnt.size() > 0), 64'd1);
      if (expGnt.size() > 0) begin
        g = expGnt.pop_front();
        checkVal("grant_onehot", 64'(bus.req_ready), 64'd1 << g);
      end
    end
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      checkVal("rsp_pending", 64'(expRsp.size() > 0), 64'd1);
      if (expRsp.size() > 0) begin
        e = expRsp.pop_front();
        checkVal("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        checkVal("rsp_y", 64'(bus.rsp_y), 64'(e.y));
        checkVal("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic waitGrant(output int g, output bit ok);
    ok = 1'b0;
    g  = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitRsp(output int lat, input longint t0);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = bus.rsp_valid ? int'(($time - t0) / 10) : -1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
    bus.req_valid = valid;
    bus.rsp_ready = ready;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkVal(name, act, exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: still running at %0t, required finish", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int     g;
    bit     ok;
    int     lat;
    longint t0;

    reset   = 1'b1;
    reqVecs = '0;
    applyStimulus(4'b0000, 1'b0);
    smp();
    smp();
    $display("[TB] reset values");
    checkOutput("reset_ctrl", {bus.req_ready, bus.eng_clear, bus.rsp_valid, bus.rsp_err, bus.busy}, '0);
    checkOutput("reset_rsp", {bus.rsp_id, bus.rsp_y}, '0);
    checkOutput("reset_eng_x", vecSig(bus.eng_x), '0);
    cyc();
    reset = 1'b0;

    $display("[TB] single job");
    stubY      = 32'h1234_5678;
    reqVecs[0] = fillVec(16'h0100);
    expGnt.push_back(0);
    expRsp.push_back(mkRsp(0, 32'h1234_5678, 1'b0));
    applyStimulus(4'b0001, 1'b1);
    waitGrant(g, ok);
    t0 = $time;
    checkOutput("t1_grant_seen", ok, 1);
    cyc();
    applyStimulus(4'b0000, 1'b1);
    smp();
    checkOutput("t1_eng_clear", bus.eng_clear, 1);
    checkOutput("t1_req_ready_off", bus.req_ready, 0);
    checkOutput("t1_eng_x", vecSig(bus.eng_x), vecSig(fillVec(16'h0100)));
    cyc();
    smp();
    checkOutput("t1_clear_single", bus.eng_clear, 0);
    waitRsp(lat, t0);
    checkOutput("t1_latency", 64'(lat), 7);
    cyc();
    smp();
    checkOutput("t1_idle_after", bus.busy, 0);

    $display("[TB] round robin");
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    stubY = 32'hCAFE_0000;
    for (int r = 0; r < NREQ; r++) reqVecs[r] = fillVec(16'(16'h0100 + r));
    for (int k = 0; k < 5; k++) begin
      expGnt.push_back(k % NREQ);
      expRsp.push_back(mkRsp(k % NREQ, 32'hCAFE_0000, 1'b0));
    end
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      waitGrant(g, ok);
      t0 = $time;
      checkOutput("t2_grant_seen", ok, 1);
      checkOutput("t2_grant_order", 64'(g), 64'(k % NREQ));
      cyc();
      if (k == 4) applyStimulus(4'b0000, 1'b1);
      smp();
      checkOutput("t2_eng_x", vecSig(bus.eng_x), vecSig(fillVec(16'(16'h0100 + k % NREQ))));
      waitRsp(lat, t0);
      checkOutput("t2_latency", 64'(lat), 7);
    end

    $display("[TB] backpressure");
    cyc();
    stubY = 32'h0BAD_F00D;
    expGnt.push_back(2);
    expRsp.push_back(mkRsp(2, 32'h0BAD_F00D, 1'b0));
    expGnt.push_back(3);
    expRsp.push_back(mkRsp(3, 32'h0BAD_F00D, 1'b0));
    applyStimulus(4'b0100, 1'b0);
    waitGrant(g, ok);
    t0 = $time;
    checkOutput("t3_grant", 64'(g), 2);
    cyc();
    applyStimulus(4'b1111, 1'b0);
    smp();
    waitRsp(lat, t0);
    checkOutput("t3_latency", 64'(lat), 7);
    for (int i = 0; i < 10; i++) begin
      cyc();
      smp();
      checkOutput("t3_hold_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.req_ready},
                  {1'b1, 2'd2, 32'h0BAD_F00D, 4'b0000});
      checkOutput("t3_hold_eng_x", vecSig(bus.eng_x), vecSig(fillVec(16'h0102)));
    end
    cyc();
    applyStimulus(4'b1111, 1'b1);
    smp();
    checkOutput("t3_no_grant_handshake", bus.req_ready, 0);
    cyc();
    smp();
    t0 = $time;
    checkOutput("t3_idle_grant", {bus.busy, bus.req_ready}, {1'b0, 4'b1000});
    cyc();
    applyStimulus(4'b0000, 1'b1);
    smp();
    waitRsp(lat, t0);
    checkOutput("t3_second_latency", 64'(lat), 7);

    $display("[TB] stale done");
    cyc();
    stubY      = 32'h5555_AAAA;
    manualMode = 1'b1;
    manualDone = 1'b1;
    expGnt.push_back(0);
    expRsp.push_back(mkRsp(0, 32'h5555_AAAA, 1'b0));
    applyStimulus(4'b0001, 1'b1);
    waitGrant(g, ok);
    t0 = $time;
    checkOutput("t4_grant", 64'(g), 0);
    cyc();
    applyStimulus(4'b0000, 1'b1);
    smp();
    waitRsp(lat, t0);
    checkOutput("t4_latency", 64'(lat), 4);
    cyc();
    manualMode = 1'b0;
    manualDone = 1'b0;

    $display("[TB] reset mid wait");
    stubNever = 1'b1;
    stubY     = 32'h3C3C_0F0F;
    expGnt.push_back(1);
    applyStimulus(4'b0010, 1'b1);
    waitGrant(g, ok);
    checkOutput("t5_grant", 64'(g), 1);
    cyc();
    applyStimulus(4'b0000, 1'b1);
    cyc();
    cyc();
    reset = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    smp();
    cyc();
    smp();
    checkOutput("t5_reset_ctrl", {bus.req_ready, bus.eng_clear, bus.rsp_valid, bus.rsp_err, bus.busy}, '0);
    checkOutput("t5_reset_rsp", {bus.rsp_id, bus.rsp_y}, '0);
    checkOutput("t5_reset_eng_x", vecSig(bus.eng_x), '0);
    stubNever = 1'b0;
    expGnt.push_back(0);
    expRsp.push_back(mkRsp(0, 32'h3C3C_0F0F, 1'b0));
    cyc();
    reset = 1'b0;
    waitGrant(g, ok);
    t0 = $time;
    checkOutput("t5_regrant", 64'(g), 0);
    cyc();
    applyStimulus(4'b0000, 1'b1);
    smp();
    waitRsp(lat, t0);
    checkOutput("t5_latency", 64'(lat), 7);

    $display("[TB] watchdog");
    cyc();
    stubNever = 1'b1;
    stubY     = 32'h7777_7777;
    expGnt.push_back(1);
`ifdef ENC_SCHED_WATCHDOG_EN
    expRsp.push_back(mkRsp(1, '0, 1'b1));
    applyStimulus(4'b0010, 1'b1);
    waitGrant(g, ok);
    t0 = $time;
    checkOutput("t6_grant", 64'(g), 1);
    cyc();
    applyStimulus(4'b0000, 1'b1);
    smp();
    waitRsp(lat, t0);
    checkOutput("t6_latency", 64'(lat), 10);
    cyc();
    smp();
    checkOutput("t6_err_cleared", {bus.rsp_err, bus.busy}, 2'b00);
`else
    applyStimulus(4'b0010, 1'b1);
    waitGrant(g, ok);
    checkOutput("t6_grant", 64'(g), 1);
    cyc();
    applyStimulus(4'b0000, 1'b1);
    repeat (100) cyc();
    smp();
    checkOutput("t6_stuck_busy", {bus.busy, bus.rsp_valid, bus.rsp_err}, 3'b100);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`endif

    cyc();
    smp();
    checkOutput("grant_queue_drained", 64'(expGnt.size()), 0);
    checkOutput("rsp_queue_drained", 64'(expRsp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
